// File: rtl/disp_mux_capture.sv
// Receive end of a 3-digit multiplexed seven-segment bus: rebuilds committed digits from ss/en.
// Commit lands one cycle after the sample; no backpressure, ss/en are free-running inputs.
module disp_mux_capture #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int STABLE_SCANS   = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ss,
  input  logic [2:0] en,
  output logic [4:0] hex2,
  output logic [4:0] hex1,
  output logic [4:0] hex0,
  output logic [2:0] dp,
  output logic [2:0] valid,
  output logic       update,
  output logic       glyph_err,
  output logic       en_err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(STABLE_SCANS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] BLANK = 5'b10000;

  // Returns {decodable, blank, hex[3:0]} for a lit-segment pattern (bit0=a .. bit6=g).
  function automatic logic [5:0] decode(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'h3F:   r = 6'b1_00000;
      7'h06:   r = 6'b1_00001;
      7'h5B:   r = 6'b1_00010;
      7'h4F:   r = 6'b1_00011;
      7'h66:   r = 6'b1_00100;
      7'h6D:   r = 6'b1_00101;
      7'h7D:   r = 6'b1_00110;
      7'h07:   r = 6'b1_00111;
      7'h7F:   r = 6'b1_01000;
      7'h6F:   r = 6'b1_01001;
      7'h77:   r = 6'b1_01010;
      7'h7C:   r = 6'b1_01011;
      7'h39:   r = 6'b1_01100;
      7'h5E:   r = 6'b1_01101;
      7'h79:   r = 6'b1_01110;
      7'h71:   r = 6'b1_01111;
      7'h00:   r = 6'b1_10000;
      default: r = 6'b0_00000;
    endcase
    return r;
  endfunction

  logic [2:0]          en_prev_q;
  logic [SW-1:0]       settle_q,  settle_d;
  logic [2:0][4:0]     cand_q,    cand_d;
  logic [2:0]          cand_dp_q, cand_dp_d;
  logic [2:0][CW-1:0]  cnt_q,     cnt_d;
  logic [2:0][TW-1:0]  to_q,      to_d;
  logic [2:0][4:0]     hex_q,     hex_d;
  logic [2:0]          dp_q,      dp_d;
  logic [2:0]          valid_q,   valid_d;
  logic                update_q,  update_d;
  logic                glyph_q,   glyph_d;
  logic                en_err_q,  en_err_d;

  logic       same_en;
  logic       one_low;
  logic       multi_low;
  logic       sample;
  logic [5:0] dec;
  logic       glyph_ok;
  logic [4:0] samp_glyph;
  logic       samp_dp;

  always_comb begin
    same_en    = (en == en_prev_q);
    one_low    = (en == 3'b110) || (en == 3'b101) || (en == 3'b011);
    multi_low  = !one_low && (en != 3'b111);
    dec        = decode(~ss[6:0]);
    glyph_ok   = dec[5];
    samp_glyph = dec[4:0];
    samp_dp    = ~ss[7];

    settle_d = '0;
    if (same_en && one_low) begin
      if (settle_q != SW'(SETTLE_CYCLES)) settle_d = settle_q + SW'(1);
      else                                settle_d = settle_q;
    end
    // Sample on the edge where the counter steps onto SETTLE_CYCLES, so it fires once per select.
    sample = same_en && one_low && (settle_q == SW'(SETTLE_CYCLES - 1));

    cand_d    = cand_q;
    cand_dp_d = cand_dp_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    hex_d     = hex_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    update_d  = 1'b0;
    glyph_d   = sample && !glyph_ok;
    en_err_d  = multi_low && !same_en;

    for (int n = 0; n < 3; n++) begin
      if (to_q[n] != TW'(TIMEOUT_CYCLES)) to_d[n] = to_q[n] + TW'(1);
      if (sample && !en[n]) begin
        if (glyph_ok) begin
          to_d[n] = '0;
          if (samp_glyph == cand_q[n] && samp_dp == cand_dp_q[n]) begin
            if (cnt_q[n] != CW'(STABLE_SCANS)) cnt_d[n] = cnt_q[n] + CW'(1);
          end else begin
            cand_d[n]    = samp_glyph;
            cand_dp_d[n] = samp_dp;
            cnt_d[n]     = CW'(1);
          end
          // A saturated count re-commits on every matching sample, which also revives a timed-out digit.
          if (cnt_d[n] == CW'(STABLE_SCANS)) begin
            if (!valid_q[n] || hex_q[n] != cand_d[n] || dp_q[n] != cand_dp_d[n]) update_d = 1'b1;
            hex_d[n]   = cand_d[n];
            dp_d[n]    = cand_dp_d[n];
            valid_d[n] = 1'b1;
          end
        end else begin
          cnt_d[n] = '0;
        end
      end
      if (to_d[n] == TW'(TIMEOUT_CYCLES)) valid_d[n] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_prev_q <= 3'b111;
      settle_q  <= '0;
      cand_q    <= {3{BLANK}};
      cand_dp_q <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      hex_q     <= {3{BLANK}};
      dp_q      <= '0;
      valid_q   <= '0;
      update_q  <= 1'b0;
      glyph_q   <= 1'b0;
      en_err_q  <= 1'b0;
    end else begin
      en_prev_q <= en;
      settle_q  <= settle_d;
      cand_q    <= cand_d;
      cand_dp_q <= cand_dp_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      update_q  <= update_d;
      glyph_q   <= glyph_d;
      en_err_q  <= en_err_d;
    end
  end

  assign hex0      = hex_q[0];
  assign hex1      = hex_q[1];
  assign hex2      = hex_q[2];
  assign dp        = dp_q;
  assign valid     = valid_q;
  assign update    = update_q;
  assign glyph_err = glyph_q;
  assign en_err    = en_err_q;

endmodule
